// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and constants for the arbitrated UART transmitter.
//   DATA_BITS   : payload bits per frame (8).
//   OVS_DEFAULT : default number of ce_16 strobes per UART bit.
//   tx_state_e  : transmitter FSM states. ST_PAR exists only when
//                 UART_TX_ARB_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned DATA_BITS   = 8;
  localparam int unsigned OVS_DEFAULT = 16;

`ifdef UART_TX_ARB_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } tx_state_e;
`endif

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick -- combinational round-robin picker.
// Ports:
//   req   [N_REQ-1:0] : request vector.
//   ptr   [2:0]       : highest-priority index (search starts here, wraps).
//   valid             : at least one request set.
//   index [2:0]       : first set request at or after ptr.
module uart_rr_pick #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic             valid,
  output logic [2:0]       index
);

  int unsigned idx;

  // Scan from the farthest offset down to offset 0 so the nearest set
  // request at or after ptr is the last one written.
  always_comb begin
    valid = 1'b0;
    index = '0;
    idx   = 0;
    for (int unsigned k = N_REQ; k > 0; k--) begin
      idx = (int'(ptr) + k - 1) % N_REQ;
      if (req[idx]) begin
        valid = 1'b1;
        index = 3'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb -- UART transmitter shared by N_REQ byte requesters with
// round-robin arbitration. Frame is 8N1, or 8E1 when UART_TX_ARB_PARITY_EN
// is defined (even parity bit inserted between data and stop).
// Ports:
//   clock, reset        : system clock, asynchronous active-high reset.
//   ce_16               : one-clock oversample strobe, OVS strobes per bit.
//   req   [N_REQ-1:0]   : per-requester byte-valid (level), sampled in idle.
//   data  [8*N_REQ-1:0] : requester bytes, requester i at [8i+7:8i].
//   ack   [N_REQ-1:0]   : one-clock pulse when a requester's byte is taken.
//   busy                : frame in progress.
//   grant_id [2:0]      : last granted requester.
//   tx                  : serial line, idle high, registered.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned OVS   = OVS_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ce_16,
  input  logic [N_REQ-1:0]       req,
  input  logic [8*N_REQ-1:0]     data,
  output logic [N_REQ-1:0]       ack,
  output logic                   busy,
  output logic [2:0]             grant_id,
  output logic                   tx
);

  localparam int unsigned TW = (OVS > 1) ? $clog2(OVS) : 1;

  tx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic [2:0]           gid_q, gid_d;
  logic [2:0]           ptr_q, ptr_d;
`ifdef UART_TX_ARB_PARITY_EN
  logic                 par_q, par_d;
`endif

  logic                 pick_valid;
  logic [2:0]           pick_idx;
  logic                 bit_end;

  uart_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .index (pick_idx)
  );

  assign bit_end = ce_16 && (tick_q == TW'(OVS - 1));

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    ack_d   = '0;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
`ifdef UART_TX_ARB_PARITY_EN
    par_d   = par_q;
`endif

    if (state_q != ST_IDLE && ce_16) begin
      tick_d = bit_end ? '0 : tick_q + TW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        tick_d = '0;
        bit_d  = '0;
        if (pick_valid) begin
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_idx == 3'(i)) begin
              shift_d  = data[i*8 +: 8];
              ack_d[i] = 1'b1;
            end
          end
`ifdef UART_TX_ARB_PARITY_EN
          par_d   = ^shift_d;
`endif
          gid_d   = pick_idx;
          ptr_d   = (pick_idx == 3'(N_REQ - 1)) ? '0 : pick_idx + 3'd1;
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_TX_ARB_PARITY_EN
            tx_d    = par_q;
            state_d = ST_PAR;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            // Byte shifts right each bit so the next bit is always at [1].
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_ARB_PARITY_EN
      ST_PAR: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ack_q   <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
`ifdef UART_TX_ARB_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ack_q   <= ack_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
`ifdef UART_TX_ARB_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign ack      = ack_q;
  assign busy     = (state_q != ST_IDLE);
  assign grant_id = gid_q;
  assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb -- randomized and directed bench for uart_tx_arb with a
// frame-level reference model (bit list + ce_16 counting).
module tb_uart_tx_arb;

  localparam int N   = 4;
  localparam int OVS = 16;
`ifdef UART_TX_ARB_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           ce_16 = 1'b0;
  logic [N-1:0]   req   = '0;
  logic [8*N-1:0] data  = '0;
  logic [N-1:0]   ack;
  logic           busy;
  logic [2:0]     grant_id;
  logic           tx;

  uart_tx_arb #(.N_REQ(N), .OVS(OVS)) dut (
    .clock    (clock),
    .reset    (reset),
    .ce_16    (ce_16),
    .req      (req),
    .data     (data),
    .ack      (ack),
    .busy     (busy),
    .grant_id (grant_id),
    .tx       (tx)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state
  logic         m_busy;
  logic         m_tx;
  logic [N-1:0] m_ack;
  int           m_gid, m_ptr, m_pos, m_cnt;
  logic         m_frame [0:FB-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_tx = 1'b1; m_ack = '0;
    m_gid = 0; m_ptr = 0; m_pos = 0; m_cnt = 0;
  endtask

  task automatic model_tick();
    logic [7:0] b;
    bit found;
    m_ack = '0;
    if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (!found && req[idx]) begin
          found = 1'b1;
          b = data[8*idx +: 8];
          m_ack[idx] = 1'b1;
          m_gid = idx;
          m_ptr = (idx + 1) % N;
          m_frame[0] = 1'b0;
          for (int j = 0; j < 8; j++) m_frame[1+j] = b[j];
          if (FB == 11) m_frame[9] = ^b;
          m_frame[FB-1] = 1'b1;
          m_pos = 0; m_cnt = 0; m_busy = 1'b1;
          m_tx = m_frame[0];
        end
      end
      if (!found) m_tx = 1'b1;
    end else if (ce_16) begin
      m_cnt++;
      if (m_cnt == OVS) begin
        m_cnt = 0;
        m_pos++;
        if (m_pos == FB) begin
          m_busy = 1'b0;
          m_tx = 1'b1;
        end else begin
          m_tx = m_frame[m_pos];
        end
      end
    end
  endtask

  // One clock: model advances with the edge, outputs compared 1 ns later,
  // returns at the following negedge ready for new inputs.
  task automatic step();
    @(posedge clock);
    model_tick();
    cyc++;
    #1;
    check("tx", 32'(tx), 32'(m_tx));
    check("busy", 32'(busy), 32'(m_busy));
    check("ack", 32'(ack), 32'(m_ack));
    check("grant_id", 32'(grant_id), 32'(m_gid));
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int mode, ph, nack, bcnt;
    int t_ack[$];
    int g_ack[$];
    model_reset();

    // Reset state and single 0xA5 frame from requester 0
    do_reset();
    ce_16 = 1'b1;
    data = '0; data[7:0] = 8'hA5;
    req = 4'b0001;
    step();
    req = '0;
    nack = (ack != 0) ? 1 : 0;
    for (int i = 0; i < FB*OVS + 5; i++) begin
      step();
      if (ack != 0) nack++;
    end
    check("a5_ack_count", 32'(nack), 32'd1);

    // Round-robin with all requests held high
    do_reset();
    req = 4'b1111;
    data = 32'h44332211;
    for (int i = 0; i < 5*(FB*OVS+1) + 3; i++) begin
      step();
      if (ack != 0) begin
        t_ack.push_back(cyc);
        g_ack.push_back(int'(grant_id));
      end
    end
    req = '0;
    check("rr_ack_seen", 32'(g_ack.size() >= 5), 32'd1);
    if (g_ack.size() >= 5) begin
      for (int k = 0; k < 5; k++) check("rr_order", 32'(g_ack[k]), 32'(k % 4));
      for (int k = 1; k < 5; k++) check("rr_spacing", 32'(t_ack[k] - t_ack[k-1]), 32'(FB*OVS + 1));
    end

    // Slow baud: ce_16 every third clock, grant aligned to a strobe
    do_reset();
    data = '0;
    ph = 0;
    ce_16 = 1'b1; ph = 1;
    req = 4'b0001;
    step();
    req = '0;
    bcnt = busy ? 1 : 0;
    for (int i = 0; i < FB*OVS*3 + 40; i++) begin
      ce_16 = (ph == 0); ph = (ph + 1) % 3;
      step();
      if (busy) bcnt++;
    end
    check("slow_busy_clocks", 32'(bcnt), 32'(FB*OVS*3));

    // Request arriving mid-frame waits for stop bit to end
    do_reset();
    ce_16 = 1'b1;
    data = 32'h5A3C_0000 | 32'($urandom_range(0, 65535));
    req = 4'b0100;
    step();
    req = '0;
    for (int i = 0; i < 70; i++) step();
    req = 4'b0010;
    for (int i = 0; i < FB*OVS; i++) step();
    req = '0;
    for (int i = 0; i < 20; i++) step();

    // Asynchronous reset inside DATA bit 4, then pointer back at 0
    do_reset();
    ce_16 = 1'b1;
    data = 32'hFFFF_FFFF;
    req = 4'b0100;
    step();
    req = '0;
    for (int i = 0; i < OVS + 4*OVS + 6; i++) step();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ack", 32'(ack), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    req = 4'b1000;
    step();
    req = '0;
    check("post_rst_grant", 32'(grant_id), 32'd3);
    for (int i = 0; i < FB*OVS + 4; i++) step();

    // Randomized traffic with mixed strobe patterns, including stalls
    mode = 0; ph = 0;
    for (int i = 0; i < 6000; i++) begin
      if (i % 250 == 0) mode = int'($urandom_range(0, 3));
      case (mode)
        0: ce_16 = 1'b1;
        1: begin ce_16 = (ph == 0); ph = (ph + 1) % 3; end
        2: ce_16 = 1'($urandom_range(0, 1));
        default: ce_16 = 1'b0;
      endcase
      if ($urandom_range(0, 7) == 0) req = N'($urandom);
      data = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
